// File: rtl/fp_exec_seq.sv
// Sequencer for the multi-cycle FP unit: launches one op at a time and holds EX until the result is captured.
// An op entering EX at cycle t stalls t..t+LAT and raises FPDoneE at t+LAT+1; there is no backpressure input.
module fp_exec_seq #(
   parameter int unsigned LAT_ADD = 3,
   parameter int unsigned LAT_MUL = 4,
   parameter int unsigned LAT_DIV = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        FPOpE,
   input  logic [2:0]  FPCtrlE,
   input  logic [31:0] FPResultX,
   input  logic [4:0]  FPFlagsX,
   input  logic        FFlagsClr,
   output logic        FPStartX,
   output logic [2:0]  FPOpX,
   output logic        StallFP,
   output logic        FPDoneE,
   output logic [31:0] FPResultE,
   output logic [4:0]  FFlags,
   output logic        FPIllegalE,
   output logic [15:0] FPStallCount
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

   localparam logic [3:0] CNT_ADD = 4'(LAT_ADD - 1);
   localparam logic [3:0] CNT_MUL = 4'(LAT_MUL - 1);
   localparam logic [3:0] CNT_DIV = 4'(LAT_DIV - 1);

   stateT      state, stateNext;
   logic [3:0] cnt, cntNext;
   logic [3:0] latCnt;
   logic       opLegal;
   logic       capture;

   assign opLegal = (FPCtrlE <= 3'd4);

   always_comb begin
      latCnt = CNT_DIV;
      case (FPCtrlE)
         3'd0, 3'd1: latCnt = CNT_ADD;
         3'd2:       latCnt = CNT_MUL;
         default:    latCnt = CNT_DIV;
      endcase
   end

   always_comb begin
      stateNext  = state;
      cntNext    = cnt;
      FPStartX   = 1'b0;
      StallFP    = 1'b0;
      FPDoneE    = 1'b0;
      FPIllegalE = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (FPOpE) begin
               if (opLegal) begin
                  FPStartX  = 1'b1;
                  StallFP   = 1'b1;
                  cntNext   = latCnt;
                  stateNext = RUN;
               end else begin
                  FPIllegalE = 1'b1;
               end
            end
         end
         RUN: begin
            StallFP = 1'b1;
            if (cnt != 4'd0) begin
               cntNext = cnt - 4'd1;
            end else begin
               capture   = 1'b1;
               stateNext = DONE;
            end
         end
         // DONE ignores FPOpE so the instruction still sitting in EX cannot relaunch.
         DONE: begin
            FPDoneE   = 1'b1;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
      if (!reset) begin
         FPStartX   = 1'b0;
         StallFP    = 1'b0;
         FPDoneE    = 1'b0;
         FPIllegalE = 1'b0;
         capture    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         FPOpX        <= 3'd0;
         FPResultE    <= 32'd0;
         FFlags       <= 5'd0;
         FPStallCount <= 16'd0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
         if (FPStartX) FPOpX <= FPCtrlE;
         if (capture) FPResultE <= FPResultX;
         // Clear takes effect first so a coincident capture still lands.
         FFlags <= (FFlagsClr ? 5'd0 : FFlags) | (capture ? FPFlagsX : 5'd0);
         if (StallFP && (FPStallCount != 16'hFFFF)) FPStallCount <= FPStallCount + 16'd1;
      end
   end

endmodule

// File: tb/tb_fp_exec_seq.sv
// Bench for fp_exec_seq: scoreboard of expected captured results plus per-cycle handshake checks.
module tb_fp_exec_seq;

   localparam int LAT_ADD = 3;
   localparam int LAT_MUL = 4;
   localparam int LAT_DIV = 12;

   logic        clk = 1'b0;
   logic        reset;
   logic        FPOpE;
   logic [2:0]  FPCtrlE;
   logic [31:0] FPResultX;
   logic [4:0]  FPFlagsX;
   logic        FFlagsClr;
   logic        FPStartX;
   logic [2:0]  FPOpX;
   logic        StallFP;
   logic        FPDoneE;
   logic [31:0] FPResultE;
   logic [4:0]  FFlags;
   logic        FPIllegalE;
   logic [15:0] FPStallCount;

   fp_exec_seq #(.LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV)) dut (
      .clk(clk), .reset(reset), .FPOpE(FPOpE), .FPCtrlE(FPCtrlE), .FPResultX(FPResultX),
      .FPFlagsX(FPFlagsX), .FFlagsClr(FFlagsClr), .FPStartX(FPStartX), .FPOpX(FPOpX),
      .StallFP(StallFP), .FPDoneE(FPDoneE), .FPResultE(FPResultE), .FFlags(FFlags),
      .FPIllegalE(FPIllegalE), .FPStallCount(FPStallCount)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          startCnt = 0;
   int          stallModel = 0;
   int          s0;
   logic [4:0]  flagsModel = 5'd0;
   logic [31:0] lastRes = 32'd0;
   logic [31:0] resQ[$];

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] resFn(input int c);
      return 32'hA5A5_0000 ^ (32'(c) * 32'h9E37_79B9);
   endfunction

   function automatic int latOf(input logic [2:0] op);
      case (op)
         3'd0, 3'd1: return LAT_ADD;
         3'd2:       return LAT_MUL;
         default:    return LAT_DIV;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      FPResultX = resFn(cyc);
   endtask

   // Monitor: pop the scoreboard on every FPDoneE; any unexpected done is flagged.
   always @(negedge clk) begin
      if (FPStartX) startCnt++;
      if (FPDoneE) begin
         if (resQ.size() == 0) checkVal("spurious_done", 32'(FPDoneE), 32'd0);
         else checkVal("result", FPResultE, resQ.pop_front());
      end
   end

   task automatic idleCycle();
      FPOpE    = 1'b0;
      FPCtrlE  = 3'd0;
      FPFlagsX = 5'd0;
      @(negedge clk);
      checkVal("idle_stall", 32'(StallFP), 32'd0);
      checkVal("idle_start", 32'(FPStartX), 32'd0);
      checkVal("idle_done", 32'(FPDoneE), 32'd0);
      checkVal("idle_illegal", 32'(FPIllegalE), 32'd0);
   endtask

   // Called at the start of the cycle the op enters EX; returns at mid-cycle of its DONE cycle.
   task automatic runOp(input logic [2:0] op, input logic [4:0] flg, input bit clrAtCap, input bit detail);
      int lat;
      lat      = latOf(op);
      FPOpE    = 1'b1;
      FPCtrlE  = op;
      FPFlagsX = flg;
      resQ.push_back(resFn(cyc + lat));
      @(negedge clk);
      if (detail) begin
         checkVal("start", 32'(FPStartX), 32'd1);
         checkVal("stall_t0", 32'(StallFP), 32'd1);
      end
      for (int i = 1; i <= lat; i++) begin
         tick();
         FFlagsClr = clrAtCap && (i == lat);
         @(negedge clk);
         if (detail) begin
            checkVal("stall_run", 32'(StallFP), 32'd1);
            checkVal("start_run", 32'(FPStartX), 32'd0);
            checkVal("done_run", 32'(FPDoneE), 32'd0);
            if (i == 1) checkVal("fpopx", 32'(FPOpX), 32'(op));
         end
      end
      tick();
      FFlagsClr  = 1'b0;
      flagsModel = clrAtCap ? flg : (flagsModel | flg);
      lastRes    = resFn(cyc - 1);
      stallModel = stallModel + lat + 1;
      if (stallModel > 65535) stallModel = 65535;
      @(negedge clk);
      checkVal("done", 32'(FPDoneE), 32'd1);
      if (detail) checkVal("stall_done", 32'(StallFP), 32'd0);
      checkVal("fflags", 32'(FFlags), 32'(flagsModel));
      checkVal("stallcnt", 32'(FPStallCount), 32'(stallModel));
   endtask

   initial begin
      reset     = 1'b0;
      FPOpE     = 1'b1;
      FPCtrlE   = 3'd0;
      FPFlagsX  = 5'd0;
      FFlagsClr = 1'b0;
      FPResultX = resFn(0);
      tick();
      tick();
      @(negedge clk);
      checkVal("rst_stall", 32'(StallFP), 32'd0);
      checkVal("rst_start", 32'(FPStartX), 32'd0);
      checkVal("rst_done", 32'(FPDoneE), 32'd0);
      checkVal("rst_illegal", 32'(FPIllegalE), 32'd0);
      checkVal("rst_fpopx", 32'(FPOpX), 32'd0);
      checkVal("rst_result", FPResultE, 32'd0);
      checkVal("rst_fflags", 32'(FFlags), 32'd0);
      checkVal("rst_stallcnt", 32'(FPStallCount), 32'd0);

      // fadd accepted on the first edge after release
      tick();
      reset = 1'b1;
      runOp(3'd0, 5'd0, 1'b0, 1'b1);
      checkVal("fadd_stallcnt", 32'(FPStallCount), 32'd4);
      tick();
      idleCycle();
      tick();
      idleCycle();
      checkVal("result_hold", FPResultE, lastRes);

      // fdiv, bubble, fmul
      s0 = startCnt;
      tick();
      runOp(3'd3, 5'd0, 1'b0, 1'b1);
      tick();
      idleCycle();
      tick();
      runOp(3'd2, 5'd0, 1'b0, 1'b1);
      checkVal("fpopx_fmul", 32'(FPOpX), 32'd2);
      tick();
      idleCycle();
      checkVal("start_pulses", 32'(startCnt - s0), 32'd2);

      // illegal op codes
      for (int op = 5; op <= 7; op++) begin
         tick();
         FPOpE   = 1'b1;
         FPCtrlE = 3'(op);
         @(negedge clk);
         checkVal("illegal", 32'(FPIllegalE), 32'd1);
         checkVal("illegal_stall", 32'(StallFP), 32'd0);
         checkVal("illegal_start", 32'(FPStartX), 32'd0);
      end
      tick();
      idleCycle();
      tick();
      runOp(3'd1, 5'd0, 1'b0, 1'b1);

      // sticky flags, clear, clear coincident with capture
      tick();
      runOp(3'd0, 5'b00001, 1'b0, 1'b1);
      tick();
      runOp(3'd2, 5'b10000, 1'b0, 1'b1);
      checkVal("fflags_or", 32'(FFlags), 32'h11);
      tick();
      FFlagsClr = 1'b1;
      idleCycle();
      tick();
      FFlagsClr = 1'b0;
      idleCycle();
      checkVal("fflags_clr", 32'(FFlags), 32'd0);
      flagsModel = 5'd0;
      tick();
      runOp(3'd4, 5'b00100, 1'b1, 1'b1);
      checkVal("fflags_clr_cap", 32'(FFlags), 32'h04);

      // reset in RUN cycle 2 of an fdiv
      tick();
      FPOpE    = 1'b1;
      FPCtrlE  = 3'd3;
      FPFlagsX = 5'b01000;
      tick();
      tick();
      reset = 1'b0;
      #1;
      checkVal("rrun_stall", 32'(StallFP), 32'd0);
      checkVal("rrun_start", 32'(FPStartX), 32'd0);
      checkVal("rrun_done", 32'(FPDoneE), 32'd0);
      checkVal("rrun_fpopx", 32'(FPOpX), 32'd0);
      checkVal("rrun_result", FPResultE, 32'd0);
      checkVal("rrun_fflags", 32'(FFlags), 32'd0);
      checkVal("rrun_stallcnt", 32'(FPStallCount), 32'd0);
      flagsModel = 5'd0;
      stallModel = 0;
      tick();
      FPOpE = 1'b0;
      tick();
      reset = 1'b1;
      idleCycle();
      for (int i = 0; i < 20; i++) begin
         tick();
         idleCycle();
      end
      checkVal("rrun_result_after", FPResultE, 32'd0);

      // continuous fdivs drive the stall counter into saturation
      while (stallModel < 65535) begin
         tick();
         runOp(3'd3, 5'd0, 1'b0, 1'b0);
      end
      repeat (2) begin
         tick();
         runOp(3'd3, 5'd0, 1'b0, 1'b1);
      end
      checkVal("stallcnt_sat", 32'(FPStallCount), 32'h0000_FFFF);
      tick();
      idleCycle();
      checkVal("queue_empty", resQ.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
